// File: rtl/arbitro_multiplicador_if.sv
// Bundle of request/grant lines and multiplier handshake between clients, arbiter and the shared multiplier.
interface arbitro_multiplicador_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  logic [N_REQ-1:0]   Req;
  logic [N_REQ*W-1:0] Op_A;
  logic [N_REQ*W-1:0] Op_B;
  logic [N_REQ-1:0]   Gnt;
  logic [N_REQ-1:0]   Ack;
  logic [2*W-1:0]     Resultado;
  logic               Busy;
  logic               Timeout;
  logic               Mul_St;
  logic [W-1:0]       Mul_A;
  logic [W-1:0]       Mul_B;
  logic               Mul_Idle;
  logic               Mul_Done;
  logic [2*W-1:0]     Mul_Produto;

  // arbiter side
  modport slave (
    input  Req, Op_A, Op_B, Mul_Idle, Mul_Done, Mul_Produto,
    output Gnt, Ack, Resultado, Busy, Timeout, Mul_St, Mul_A, Mul_B
  );

  // clients plus multiplier side
  modport master (
    output Req, Op_A, Op_B, Mul_Idle, Mul_Done, Mul_Produto,
    input  Gnt, Ack, Resultado, Busy, Timeout, Mul_St, Mul_A, Mul_B
  );
endinterface

// File: rtl/arbitro_multiplicador.sv
// Round-robin arbiter sharing one multiplier among N_REQ clients; grant->Mul_St 1 cycle, Mul_Done->Ack 1 cycle.
// Clients hold Req until their Ack; optional ARB_TIMEOUT_EN adds a watchdog that forces Ack with Resultado=0.
module arbitro_multiplicador #(
  parameter int N_REQ          = 4,
  parameter int W              = 4,
  parameter int TIMEOUT_CICLOS = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  arbitro_multiplicador_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {OCIOSO, INICIA, ESPERA, ENTREGA} estado_t;

  estado_t            estado, estado_nx;
  logic [PW-1:0]      ptr, ptr_nx, vencedor, cand;
  logic               cand_vld;
  logic [PW:0]        suma, prox;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       mul_a, mul_b;
  logic [2*W-1:0]     resultado;
  logic               fim_timeout;

  // First set Req at or after ptr, wrapping modulo N_REQ
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    suma     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      suma = {1'b0, ptr} + (PW+1)'(i);
      if (suma >= (PW+1)'(N_REQ))
        suma = suma - (PW+1)'(N_REQ);
      if (!cand_vld && bus.Req[suma[PW-1:0]]) begin
        cand_vld = 1'b1;
        cand     = suma[PW-1:0];
      end
    end
  end

  always_comb begin
    prox   = {1'b0, vencedor} + (PW+1)'(1);
    ptr_nx = (prox == (PW+1)'(N_REQ)) ? '0 : prox[PW-1:0];
  end

  always_comb begin
    estado_nx = estado;
    unique case (estado)
      OCIOSO:  if (cand_vld && bus.Mul_Idle) estado_nx = INICIA;
      INICIA:  begin
        if (fim_timeout)        estado_nx = ENTREGA;
        else if (!bus.Mul_Idle) estado_nx = ESPERA;
      end
      ESPERA:  if (bus.Mul_Done || fim_timeout) estado_nx = ENTREGA;
      ENTREGA: estado_nx = OCIOSO;
      default: estado_nx = OCIOSO;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      estado    <= OCIOSO;
      ptr       <= '0;
      vencedor  <= '0;
      gnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      resultado <= '0;
    end else begin
      estado <= estado_nx;
      case (estado)
        OCIOSO: begin
          if (estado_nx == INICIA) begin
            vencedor <= cand;
            gnt      <= N_REQ'(1) << cand;
            mul_a    <= bus.Op_A[cand*W +: W];
            mul_b    <= bus.Op_B[cand*W +: W];
          end
        end
        INICIA: begin
          if (fim_timeout) resultado <= '0;
        end
        ESPERA: begin
          if (bus.Mul_Done)     resultado <= bus.Mul_Produto;
          else if (fim_timeout) resultado <= '0;
        end
        ENTREGA: begin
          gnt <= '0;
          ptr <= ptr_nx;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

  logic [CW-1:0] contador;
  logic          timeout_q;

  // Expire on the edge where the count would reach the limit, so Ack lands TIMEOUT_CICLOS cycles after grant
  assign fim_timeout = (estado == INICIA || (estado == ESPERA && !bus.Mul_Done)) &&
                       (contador == CW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      contador  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= fim_timeout;
      if (estado == OCIOSO)
        contador <= '0;
      else if (estado == INICIA || estado == ESPERA)
        contador <= contador + CW'(1);
    end
  end

  assign bus.Timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CICLOS;
  assign fim_timeout = 1'b0;
  assign bus.Timeout = 1'b0;
`endif

  assign bus.Gnt       = gnt;
  assign bus.Ack       = (estado == ENTREGA) ? gnt : '0;
  assign bus.Resultado = resultado;
  assign bus.Busy      = (estado != OCIOSO);
  assign bus.Mul_St    = (estado == INICIA);
  assign bus.Mul_A     = mul_a;
  assign bus.Mul_B     = mul_b;
endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Directed bench: vector table of single transactions plus hand-written multi-cycle sequences around a model multiplier.
module tb_arbitro_multiplicador;
  localparam int N    = 4;
  localparam int W    = 4;
  localparam int MLAT = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  arbitro_multiplicador_if #(.N_REQ(N), .W(W)) bus();

  arbitro_multiplicador #(.N_REQ(N), .W(W), .TIMEOUT_CICLOS(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Model multiplier: accepts St while idle, Done+Idle after MLAT cycles, never reset by Rst
  logic       m_idle = 1'b1;
  logic       m_done = 1'b0;
  logic [7:0] m_prod = 8'd0;
  logic       m_busy = 1'b0;
  logic       hang   = 1'b0;
  logic [7:0] m_a    = 8'd0;
  logic [7:0] m_b    = 8'd0;
  int         m_cnt  = 0;

  assign bus.Mul_Idle    = m_idle;
  assign bus.Mul_Done    = m_done;
  assign bus.Mul_Produto = m_prod;

  always @(posedge Clk) begin
    m_done <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 1) begin
        if (!hang) begin
          m_done <= 1'b1;
          m_prod <= m_a * m_b;
          m_idle <= 1'b1;
          m_busy <= 1'b0;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (bus.Mul_St && m_idle) begin
      m_busy <= 1'b1;
      m_idle <= 1'b0;
      m_cnt  <= MLAT;
      m_a    <= {4'b0, bus.Mul_A};
      m_b    <= {4'b0, bus.Mul_B};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nome, act, exp);
    end
  endtask

  task automatic wait_ack(input string nome, output int slot);
    slot = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge Clk);
      if (bus.Ack != '0) begin
        for (int j = 0; j < N; j++)
          if (bus.Ack[j]) slot = j;
        break;
      end
    end
    if (slot < 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_ack required=ack_within_300", nome);
    end
  endtask

  task automatic wait_espera(input string nome);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge Clk);
      if (bus.Busy && !bus.Mul_St && !bus.Mul_Idle) begin
        ok = 1'b1;
        break;
      end
    end
    check(nome, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst     = 1'b1;
    bus.Req = '0;
    @(negedge Clk);
    Rst     = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] op_a;
    logic [15:0] op_b;
    int          slot;
    logic [7:0]  prod;
  } vec_t;

  vec_t       tabela[6];
  int         s;
  logic [3:0] um;
  logic [3:0] exp_oh;
  logic [15:0] ops;
  logic       bad;
  int         cnt;

  initial begin
    // Pointer evolves 0 ->1 ->1 ->0 ->2 ->3 ->1 across the table
    tabela[0] = '{4'b0001, 16'h000D, 16'h000B, 0, 8'd143};
    tabela[1] = '{4'b0001, 16'h000F, 16'h000F, 0, 8'd225};
    tabela[2] = '{4'b1001, 16'hF002, 16'hE003, 3, 8'd210};
    tabela[3] = '{4'b0110, 16'h0700, 16'h0890, 1, 8'd0};
    tabela[4] = '{4'b0101, 16'h0F09, 16'h0109, 2, 8'd15};
    tabela[5] = '{4'b0011, 16'h0051, 16'h005F, 0, 8'd15};
    um = 4'b0001;

    bus.Req  = '0;
    bus.Op_A = '0;
    bus.Op_B = '0;
    repeat (3) @(negedge Clk);
    check("rst_ctrl", 32'({bus.Gnt, bus.Ack, bus.Busy, bus.Mul_St, bus.Timeout}), 32'd0);
    check("rst_data", 32'({bus.Mul_A, bus.Mul_B, bus.Resultado}), 32'd0);
    Rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      @(negedge Clk);
      bus.Req  = tabela[v].req;
      bus.Op_A = tabela[v].op_a;
      bus.Op_B = tabela[v].op_b;
      wait_ack($sformatf("vec%0d_wait", v), s);
      exp_oh = um << tabela[v].slot;
      check($sformatf("vec%0d_ack", v), 32'(bus.Ack), 32'(exp_oh));
      check($sformatf("vec%0d_gnt", v), 32'(bus.Gnt), 32'(exp_oh));
      check($sformatf("vec%0d_res", v), 32'(bus.Resultado), 32'(tabela[v].prod));
      ops = tabela[v].op_a;
      check($sformatf("vec%0d_mul_a", v), 32'(bus.Mul_A), 32'(ops[tabela[v].slot*4 +: 4]));
      check($sformatf("vec%0d_tmo", v), 32'(bus.Timeout), 32'd0);
      bus.Req = '0;
      @(negedge Clk);
      check($sformatf("vec%0d_after", v), 32'({bus.Gnt, bus.Busy}), 32'd0);
    end

    // Simultaneous requests: slot0 then slot1, then ptr=2 favours slot2 over slot0
    do_reset();
    bus.Req  = 4'b0011;
    bus.Op_A = 16'h003F;
    bus.Op_B = 16'h005F;
    wait_ack("sim0_wait", s);
    check("sim0_ack", 32'(bus.Ack), 32'h1);
    check("sim0_res", 32'(bus.Resultado), 32'd225);
    bus.Req = 4'b0010;
    @(negedge Clk);
    check("sim_gap_gnt", 32'({bus.Gnt, bus.Busy}), 32'd0);
    wait_ack("sim1_wait", s);
    check("sim1_ack", 32'(bus.Ack), 32'h2);
    check("sim1_res", 32'(bus.Resultado), 32'd15);
    bus.Req  = 4'b0101;
    bus.Op_A = 16'h0200;
    bus.Op_B = 16'h0200;
    wait_ack("sim2_wait", s);
    check("sim2_ptr_ack", 32'(bus.Ack), 32'h4);
    check("sim2_res", 32'(bus.Resultado), 32'd4);
    bus.Req = '0;

    // Fairness with all requests held
    do_reset();
    bus.Req  = 4'b1111;
    bus.Op_A = 16'h4321;
    bus.Op_B = 16'h2222;
    for (int k = 0; k < 6; k++) begin
      wait_ack($sformatf("rr%0d_wait", k), s);
      exp_oh = um << (k % 4);
      check($sformatf("rr%0d_ack", k), 32'(bus.Ack), 32'(exp_oh));
      check($sformatf("rr%0d_res", k), 32'(bus.Resultado), 32'(2 * ((k % 4) + 1)));
      if (k == 5) bus.Req = '0;
    end

    // Req drop and operand change during ESPERA
    do_reset();
    bus.Req  = 4'b0100;
    bus.Op_A = 16'h0600;
    bus.Op_B = 16'h0700;
    wait_espera("drop_espera");
    bus.Req  = 4'b0001;
    bus.Op_A = 16'h0103;
    bus.Op_B = 16'h0103;
    wait_ack("drop_wait", s);
    check("drop_ack", 32'(bus.Ack), 32'h4);
    check("drop_gnt", 32'(bus.Gnt), 32'h4);
    check("drop_res", 32'(bus.Resultado), 32'd42);
    check("drop_mul_a", 32'(bus.Mul_A), 32'd6);
    wait_ack("drop_next_wait", s);
    check("drop_next_ack", 32'(bus.Ack), 32'h1);
    check("drop_next_res", 32'(bus.Resultado), 32'd9);
    bus.Req = '0;

    // Reset while the multiplier is busy
    do_reset();
    bus.Req  = 4'b0001;
    bus.Op_A = 16'h0005;
    bus.Op_B = 16'h0005;
    wait_espera("mrst_espera");
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("mrst_ctrl", 32'({bus.Gnt, bus.Ack, bus.Busy, bus.Mul_St, bus.Timeout}), 32'd0);
    check("mrst_data", 32'({bus.Mul_A, bus.Mul_B, bus.Resultado}), 32'd0);
    bus.Op_A = 16'h0004;
    bus.Op_B = 16'h0003;
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.Mul_Idle) break;
      if (bus.Gnt != '0) bad = 1'b1;
      @(negedge Clk);
    end
    check("mrst_no_grant_busy", 32'(bad), 32'd0);
    @(negedge Clk);
    check("mrst_stray_done", 32'(bus.Resultado), 32'd0);
    wait_ack("mrst_wait", s);
    check("mrst_ack", 32'(bus.Ack), 32'h1);
    check("mrst_res", 32'(bus.Resultado), 32'd12);
    bus.Req = '0;

    // Multiplier never finishes
    do_reset();
    hang     = 1'b1;
    bus.Req  = 4'b1000;
    bus.Op_A = 16'h3000;
    bus.Op_B = 16'h3000;
`ifdef ARB_TIMEOUT_EN
    bad = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (bus.Gnt != '0) begin
        bad = 1'b0;
        break;
      end
    end
    check("tmo_grant", 32'(bad), 32'd0);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      cnt++;
      if (bus.Ack != '0) break;
    end
    check("tmo_latency", 32'(cnt), 32'd32);
    check("tmo_ack", 32'(bus.Ack), 32'h8);
    check("tmo_flag", 32'(bus.Timeout), 32'd1);
    check("tmo_res", 32'(bus.Resultado), 32'd0);
`else
    @(negedge Clk);
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (bus.Ack != '0 || !bus.Busy || bus.Timeout) bad = 1'b1;
    end
    check("hang_busy_no_ack", 32'(bad), 32'd0);
`endif
    bus.Req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
